// File: rtl/asip_pkg.sv
// Shared constants and types for the 24-bit audio ASIP pipeline.
package asip_pkg;

  localparam int N = 24;
  localparam logic [N-1:0] LAST_ADDR = 24'd255;
  localparam logic [N-1:0] HALT_INSTR = 24'hFFFFFF;

  localparam logic SCRIPT_REVERB = 1'b0;
  localparam logic SCRIPT_DEREVERB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register: flush clears valid but keeps the payload,
// enable captures a new payload and marks it valid, otherwise everything holds.
module ifid_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d_instr,
  input  logic [W-1:0] d_pc,
  input  logic [W-1:0] d_pc_plus1,
  output logic         valid,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_plus1
);

  // Valid bit: flush wins over capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= 1'b1;
    end
  end

  // Payload: only a non-flushed enabled cycle loads new fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      pc       <= '0;
      pc_plus1 <= '0;
    end else if (en && !flush) begin
      instr    <= d_instr;
      pc       <= d_pc;
      pc_plus1 <= d_pc_plus1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, sequences start/halt, applies
// stall and redirect, and feeds the IF/ID register.
// There is no valid/ready handshake here: stall is a plain hold request
// from decode, and redirect_valid is a one-cycle command that is acted on
// in the same cycle it is seen (no acknowledge).
module fetch_unit
  import asip_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         script_sel_in,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_addr,
  output logic         imem_sel,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  output logic         ifid_valid,
  output logic [N-1:0] ifid_instr,
  output logic [N-1:0] ifid_pc,
  output logic [N-1:0] ifid_pc_plus1,
  output logic         busy,
  output logic         done,
  output logic         err,
  output fetch_state_t dbg_state
);

  fetch_state_t state_q, state_nxt;
  logic [N-1:0] pc_q, pc_nxt;
  logic         sel_q, sel_nxt;
  logic         err_q, err_nxt;
  logic         ifid_en;
  logic         ifid_flush;

  // State, PC, script select and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sel_q   <= SCRIPT_REVERB;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      sel_q   <= sel_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state and PC update; redirect outranks stall, stall outranks halt.
  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    sel_nxt   = sel_q;
    err_nxt   = err_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          sel_nxt   = script_sel_in;
          err_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          if (redirect_addr <= LAST_ADDR) begin
            pc_nxt = redirect_addr;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = HALT;
          end
        end else if (!stall) begin
          if (imem_instr == HALT_INSTR || pc_q == LAST_ADDR) begin
            state_nxt = HALT;
          end else begin
            pc_nxt = pc_q + 24'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outside RUN the register is kept empty; this also drops the last
  // delivered word one cycle after halt and clears it on restart.
  assign ifid_flush = (state_q != RUN) || redirect_valid;
  assign ifid_en    = (state_q == RUN) && !stall;

  ifid_reg #(.W(N)) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (ifid_en),
    .flush      (ifid_flush),
    .d_instr    (imem_instr),
    .d_pc       (pc_q),
    .d_pc_plus1 (pc_q + 24'd1),
    .valid      (ifid_valid),
    .instr      (ifid_instr),
    .pc         (ifid_pc),
    .pc_plus1   (ifid_pc_plus1)
  );

  assign imem_addr = pc_q;
  assign imem_sel  = sel_q;
  assign err       = err_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == HALT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;
  import asip_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         script_sel_in;
  logic         stall;
  logic         redirect_valid;
  logic [N-1:0] redirect_addr;
  logic         imem_sel;
  logic [N-1:0] imem_addr;
  logic [N-1:0] imem_instr;
  logic         ifid_valid;
  logic [N-1:0] ifid_instr;
  logic [N-1:0] ifid_pc;
  logic [N-1:0] ifid_pc_plus1;
  logic         busy;
  logic         done;
  logic         err;
  fetch_state_t dbg_state;

  logic [N-1:0] mem [0:255];
  int total;
  int bad;

  // Clock and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instr = (imem_addr <= 24'd255) ? mem[imem_addr[7:0]] : 24'h0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .script_sel_in  (script_sel_in),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_sel       (imem_sel),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus1  (ifid_pc_plus1),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .dbg_state      (dbg_state)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 24'(i) + 24'h10;
  endtask

  task automatic pulse_start(input logic sel);
    start = 1'b1;
    script_sel_in = sel;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    script_sel_in = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    fill_mem();
    #12;
    total++;
    if ({imem_sel, imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, busy, done, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got sel=%0b addr=%h v=%0b pc=%h busy=%0b done=%0b err=%0b exp all zero",
               imem_sel, imem_addr, ifid_valid, ifid_pc, busy, done, err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_script_halt();
    mem[0] = 24'h000001; mem[1] = 24'h000002; mem[2] = 24'h000003; mem[3] = HALT_INSTR;
    pulse_start(1'b1);
    total++;
    if (imem_sel !== 1'b1 || busy !== 1'b1 || imem_addr !== 24'h0) begin
      bad++;
      $display("FAIL start_sel got sel=%0b busy=%0b addr=%h exp 1 1 000000", imem_sel, busy, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 24'(i) || ifid_instr !== mem[i] || ifid_pc_plus1 !== 24'(i + 1)) begin
        bad++;
        $display("FAIL halt_seq[%0d] got v=%0b pc=%h ins=%h p1=%h exp 1 %h %h %h",
                 i, ifid_valid, ifid_pc, ifid_instr, ifid_pc_plus1, 24'(i), mem[i], 24'(i + 1));
      end
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL halt_entry got done=%0b busy=%0b exp 1 0", done, busy);
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== 24'h3) begin
      bad++;
      $display("FAIL halt_after got done=%0b busy=%0b v=%0b addr=%h exp 1 0 0 000003", done, busy, ifid_valid, imem_addr);
    end
  endtask

  task automatic test_stall();
    fill_mem();
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (imem_addr !== 24'h5 || ifid_pc !== 24'h4) begin
      bad++;
      $display("FAIL stall_setup got addr=%h pc=%h exp 000005 000004", imem_addr, ifid_pc);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (imem_addr !== 24'h5 || ifid_pc !== 24'h4 || ifid_instr !== 24'h14 || ifid_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d] got addr=%h pc=%h ins=%h v=%0b exp 000005 000004 000014 1",
                 i, imem_addr, ifid_pc, ifid_instr, ifid_valid);
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (ifid_pc !== 24'h5 || ifid_instr !== 24'h15 || ifid_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_release got pc=%h ins=%h v=%0b exp 000005 000015 1", ifid_pc, ifid_instr, ifid_valid);
    end
    tick();
    total++;
    if (ifid_pc !== 24'h6 || imem_addr !== 24'h7) begin
      bad++;
      $display("FAIL stall_next got pc=%h addr=%h exp 000006 000007", ifid_pc, imem_addr);
    end
  endtask

  task automatic test_redirect_priority();
    mem[7] = HALT_INSTR;
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 24'h000040;
    tick();
    stall = 1'b0;
    redirect_valid = 1'b0;
    mem[7] = 24'h17;
    total++;
    if (ifid_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || imem_addr !== 24'h40 || ifid_pc !== 24'h6) begin
      bad++;
      $display("FAIL redirect_flush got v=%0b busy=%0b done=%0b addr=%h pc=%h exp 0 1 0 000040 000006",
               ifid_valid, busy, done, imem_addr, ifid_pc);
    end
    tick();
    total++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 24'h40 || ifid_pc_plus1 !== 24'h41 || ifid_instr !== 24'h50) begin
      bad++;
      $display("FAIL redirect_capture got v=%0b pc=%h p1=%h ins=%h exp 1 000040 000041 000050",
               ifid_valid, ifid_pc, ifid_pc_plus1, ifid_instr);
    end
  endtask

  task automatic test_bad_redirect();
    redirect_valid = 1'b1;
    redirect_addr = 24'h000100;
    tick();
    total++;
    if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || ifid_valid !== 1'b0) begin
      bad++;
      $display("FAIL bad_redirect got err=%0b done=%0b busy=%0b v=%0b exp 1 1 0 0", err, done, busy, ifid_valid);
    end
    redirect_addr = 24'h000010;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (imem_addr !== 24'h41 || done !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL halt_ignores_redirect got addr=%h done=%0b err=%0b exp 000041 1 1", imem_addr, done, err);
    end
    pulse_start(1'b0);
    total++;
    if (err !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || imem_addr !== 24'h0 || ifid_valid !== 1'b0) begin
      bad++;
      $display("FAIL restart_clears got err=%0b busy=%0b done=%0b addr=%h v=%0b exp 0 1 0 000000 0",
               err, busy, done, imem_addr, ifid_valid);
    end
  endtask

  task automatic test_last_addr();
    int seq_bad;
    seq_bad = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (ifid_valid !== 1'b1 || ifid_pc !== 24'(i)) seq_bad++;
    end
    total++;
    if (seq_bad !== 0) begin
      bad++;
      $display("FAIL straight_line_seq got bad_steps=%0d exp 0", seq_bad);
    end
    total++;
    if (ifid_pc !== 24'hFF || ifid_valid !== 1'b1 || ifid_instr !== 24'h10F || done !== 1'b1) begin
      bad++;
      $display("FAIL last_addr got pc=%h v=%0b ins=%h done=%0b exp 0000ff 1 00010f 1",
               ifid_pc, ifid_valid, ifid_instr, done);
    end
    tick();
    total++;
    if (imem_addr !== 24'hFF || ifid_valid !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL no_wrap got addr=%h v=%0b done=%0b exp 0000ff 0 1", imem_addr, ifid_valid, done);
    end
  endtask

  task automatic test_async_reset();
    pulse_start(1'b1);
    for (int i = 0; i < 32; i++) tick();
    total++;
    if (imem_addr !== 24'h20 || busy !== 1'b1 || imem_sel !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got addr=%h busy=%0b sel=%0b exp 000020 1 1", imem_addr, busy, imem_sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({imem_sel, imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, busy, done, err} !== '0) begin
      bad++;
      $display("FAIL async_reset got sel=%0b addr=%h v=%0b pc=%h busy=%0b done=%0b err=%0b exp all zero",
               imem_sel, imem_addr, ifid_valid, ifid_pc, busy, done, err);
    end
    #2;
    rst_n = 1'b1;
    tick();
    pulse_start(1'b0);
    total++;
    if (imem_sel !== 1'b0 || imem_addr !== 24'h0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_start got sel=%0b addr=%h busy=%0b exp 0 000000 1", imem_sel, imem_addr, busy);
    end
    tick();
    total++;
    if (ifid_valid !== 1'b1 || ifid_pc !== 24'h0 || ifid_instr !== 24'h10) begin
      bad++;
      $display("FAIL post_reset_fetch got v=%0b pc=%h ins=%h exp 1 000000 000010", ifid_valid, ifid_pc, ifid_instr);
    end
  endtask

  // Test sequence and final report
  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_script_halt();
    test_stall();
    test_redirect_priority();
    test_bad_redirect();
    test_last_addr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 24-bit audio ASIP.
- Owns the PC and drives the address and script select of the instruction memory (256 x 24-bit, word-indexed, combinational read, ~1 ns delay).
- Registers the returned word plus its PC into the IF/ID pipeline register consumed by decode.
- Handles start/halt sequencing, stall, and branch/jump redirect with flush.

Parameters:
- N, 24, instruction and address width.
- LAST_ADDR, 255, highest valid instruction address (memory depth - 1).
- HALT_INSTR, 24'hFFFFFF, encoding that terminates a script.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a script run from address 0.
- script_sel_in  in  1  script chosen at start: 0 = reverberation, 1 = dereverberation.
- stall  in  1  hazard stall from decode; freezes PC and IF/ID.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_addr  in  N  target address.
- imem_sel  out  1  script select to instruction memory.
- imem_addr  out  N  fetch address (= PC).
- imem_instr  in  N  word returned by instruction memory.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_instr  out  N  fetched instruction.
- ifid_pc  out  N  address of ifid_instr.
- ifid_pc_plus1  out  N  ifid_pc + 1, mod 2^N.
- busy  out  1  FSM in RUN.
- done  out  1  FSM in HALT; cleared only by start or reset.
- err  out  1  sticky; set on out-of-range redirect.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, PC=0, imem_sel=0, and all outputs 0. Reset takes effect immediately, including mid-run. The IF/ID contents are discarded.
- FSM states: IDLE, RUN, HALT.
  - IDLE --start--> RUN: PC<=0, imem_sel<=script_sel_in, err<=0, ifid_valid<=0.
  - HALT --start--> RUN: same actions as IDLE --start--> RUN.
  - start while in RUN: ignored. imem_sel never changes during RUN.
- imem_addr = PC combinationally. The IF/ID capture of imem_instr occurs at the next rising edge (0-cycle memory latency; the clock period must exceed the memory delay).
- RUN, per cycle, in priority order:
  1. redirect_valid=1 (priority over stall and halt):
     - IF/ID flushed: ifid_valid<=0, instruction fields held.
     - If redirect_addr <= LAST_ADDR: PC<=redirect_addr.
     - If redirect_addr > LAST_ADDR: err<=1, go HALT.
  2. stall=1: PC, IF/ID and ifid_valid all hold.
  3. Otherwise:
     - Capture: ifid_instr<=imem_instr, ifid_pc<=PC, ifid_pc_plus1<=PC+1, ifid_valid<=1.
     - If imem_instr==HALT_INSTR or PC==LAST_ADDR: the captured word is delivered (valid), then go HALT.
     - Else PC<=PC+1.
- HALT:
  - ifid_valid<=0 from the cycle after entry; PC holds; done=1.
  - redirect and stall are ignored.
- A halt word fetched in a redirect cycle is squashed and does not halt.
- A halt word fetched under stall takes effect only on the first unstalled cycle.
- PC arithmetic is unsigned N-bit. No wrap occurs in RUN because LAST_ADDR bounds it.
- busy/done are Moore outputs of the FSM state.

Decomposition:
- Shared package asip_pkg:
  - N, LAST_ADDR and HALT_INSTR constants.
  - FSM state enum fetch_state_t {IDLE, RUN, HALT}.
  - Script select constants SCRIPT_REVERB=0, SCRIPT_DEREVERB=1.
- One natural sub-module: ifid_reg, the IF/ID pipeline register with enable (~stall) and flush (redirect) inputs. It is reused by later pipeline registers.
- The FSM and PC logic stay in fetch_unit.

Test Plan:
1. Reset then start with script_sel_in=1; memory holds words 0x000001..0x000003 then HALT_INSTR at address 3:
   - imem_sel=1.
   - ifid_pc sequence 0,1,2,3 with valid on consecutive cycles.
   - Next cycle done=1, busy=0, ifid_valid=0.
2. Stall held high for 3 cycles while PC=5:
   - imem_addr stays 5 and IF/ID holds the word from address 4.
   - After release, ifid_pc=5 with no skipped or duplicated address.
3. redirect_valid=1, redirect_addr=0x000040 in the same cycle as stall=1 and the fetched word=HALT_INSTR:
   - ifid_valid=0 next cycle, no halt, PC=0x40.
   - The following capture has ifid_pc=0x40 and ifid_pc_plus1=0x41.
4. Redirect to 0x000100 (>LAST_ADDR):
   - err=1 and done=1 next cycle.
   - A subsequent start clears err and restarts from PC=0.
5. Straight-line script with no halt word:
   - Address 255 is delivered valid with ifid_pc=0xFF, then HALT entered.
   - PC never reaches 256.
6. rst_n asserted asynchronously mid-RUN at PC=0x20 (between clock edges):
   - All outputs 0 immediately.
   - start with script_sel_in=0 gives imem_sel=0 and fetch resuming from address 0.
